// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
// Carries the read ports, both write ports, the reserve request and the
// pending count. The master drives addresses, writes and reserves. The
// slave (the register file) drives read data, busy flags and pend_cnt.
// There is no handshake: every input is sampled on each rising clk edge.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wa_en;
   logic [ADDR_W-1:0]        wa_addr;
   logic [DATA_W-1:0]        wa_data;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_addr;
   logic [DATA_W-1:0]        wb_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic [ADDR_W:0]          pend_cnt;

   modport master (
      output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             rsv_en, rsv_addr,
      input  rd_data, rd_busy, pend_cnt
   );

   modport slave (
      input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             rsv_en, rsv_addr,
      output rd_data, rd_busy, pend_cnt
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a pending scoreboard.
// - Entry 0 is hardwired to zero. It is never written and never pending.
// - Write port A carries ALU writeback. Write port B carries load returns.
//   Port B wins on an address collision, and a port B write clears pending.
// - A reserve marks a register pending because a load is outstanding. If a
//   reserve and a port B write hit the same register in one cycle, the
//   reserve wins, because the new load supersedes the one returning.
// - pend_cnt is a registered population count of the pending bits.
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, a read in the
// same cycle as a write to that register returns the write data directly, and
// a port B write in that cycle hides the busy flag.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   // Entry 0 exists only to keep indexing simple. It is reset and never written.
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_pend;
   logic [ADDR_W:0]   r_pend_cnt;

   logic [DEPTH-1:0]  w_pend_nxt;
   logic [ADDR_W:0]   w_pend_cnt_nxt;
   logic              w_wa_hit;
   logic              w_wb_hit;

   // Writes to entry 0 are discarded at the source.
   assign w_wa_hit = bus.wa_en && (bus.wa_addr != '0);
   assign w_wb_hit = bus.wb_en && (bus.wb_addr != '0);

   // Storage update: port A is applied first, so port B overrides it on a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else begin
         if (w_wa_hit) begin
            r_mem[bus.wa_addr] <= bus.wa_data;
         end
         if (w_wb_hit) begin
            r_mem[bus.wb_addr] <= bus.wb_data;
         end
      end
   end

   // Next pending vector: a load return clears the bit, then a reserve sets it.
   always_comb begin
      w_pend_nxt = r_pend;
      if (bus.wb_en) begin
         w_pend_nxt[bus.wb_addr] = 1'b0;
      end
      if (bus.rsv_en) begin
         w_pend_nxt[bus.rsv_addr] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   // Population count of the next pending vector, registered alongside it.
   always_comb begin
      w_pend_cnt_nxt = '0;
      for (int k = 1; k < DEPTH; k++) begin
         w_pend_cnt_nxt = w_pend_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[k]};
      end
   end

   // Pending scoreboard and its count move together on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend     <= '0;
         r_pend_cnt <= '0;
      end else begin
         r_pend     <= w_pend_nxt;
         r_pend_cnt <= w_pend_cnt_nxt;
      end
   end

   assign bus.pend_cnt = r_pend_cnt;

   // Combinational read ports, with optional same-cycle bypass and forced zero for entry 0.
   always_comb begin
      logic [ADDR_W-1:0] v_addr;
      logic [DATA_W-1:0] v_data;
      logic              v_busy;
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         v_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
         v_data = r_mem[v_addr];
         v_busy = r_pend[v_addr];
`ifdef REGFILE_BYPASS_EN
         if (w_wa_hit && (bus.wa_addr == v_addr)) begin
            v_data = bus.wa_data;
         end
         if (w_wb_hit && (bus.wb_addr == v_addr)) begin
            v_data = bus.wb_data;
            if (!(bus.rsv_en && (bus.rsv_addr == v_addr))) begin
               v_busy = 1'b0;
            end
         end
`endif
         if (v_addr == '0) begin
            v_data = '0;
            v_busy = 1'b0;
         end
         bus.rd_data[i*DATA_W +: DATA_W] = v_data;
         bus.rd_busy[i]                  = v_busy;
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed bench for regfile_mp with a scoreboard.
// The driver applies one cycle of stimulus at each falling edge. From a plain
// array model it computes what the read ports must show before the next
// rising edge and pushes that into exp_q, then advances the model. A separate
// monitor pops exp_q shortly after each falling edge and compares the result.
module tb_regfile_mp;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic [NUM_RD*DATA_W-1:0] data;
      logic [NUM_RD-1:0]        busy;
      logic [ADDR_W:0]          cnt;
   } exp_t;

   logic clk;
   logic rst;
   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

   regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      rst          = 1'b1;
      bus.rd_addr  = '0;
      bus.wa_en    = 1'b0;
      bus.wa_addr  = '0;
      bus.wa_data  = '0;
      bus.wb_en    = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      bus.rsv_en   = 1'b0;
      bus.rsv_addr = '0;
   end

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] m_mem  [DEPTH];
   bit                m_pend [DEPTH];
   exp_t              exp_q[$];
   int                n_tests = 0;
   int                n_fail  = 0;

   function automatic int model_count();
      int c = 0;
      for (int k = 0; k < DEPTH; k++) if (m_pend[k]) c++;
      return c;
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1,
                       input logic wae, input logic [ADDR_W-1:0] waa, input logic [DATA_W-1:0] wad,
                       input logic wbe, input logic [ADDR_W-1:0] wba, input logic [DATA_W-1:0] wbd,
                       input logic rse, input logic [ADDR_W-1:0] rsa, input logic do_rst);
      exp_t e;
      logic [ADDR_W-1:0] ra [NUM_RD];
      @(negedge clk);
      ra[0] = ra0;
      ra[1] = ra1;
      bus.rd_addr  = {ra1, ra0};
      bus.wa_en    = wae;
      bus.wa_addr  = waa;
      bus.wa_data  = wad;
      bus.wb_en    = wbe;
      bus.wb_addr  = wba;
      bus.wb_data  = wbd;
      bus.rsv_en   = rse;
      bus.rsv_addr = rsa;
      rst          = do_rst;
      if (do_rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_pend[k] = 0;
         end
      end
      e = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic [DATA_W-1:0] d;
         logic              b;
         d = m_mem[ra[i]];
         b = m_pend[ra[i]];
`ifdef REGFILE_BYPASS_EN
         if (!do_rst) begin
            if (wae && waa == ra[i]) d = wad;
            if (wbe && wba == ra[i]) begin
               d = wbd;
               if (!(rse && rsa == ra[i])) b = 1'b0;
            end
         end
`endif
         if (ra[i] == 0) begin
            d = '0;
            b = 1'b0;
         end
         e.data[i*DATA_W +: DATA_W] = d;
         e.busy[i]                  = b;
      end
      e.cnt = (ADDR_W + 1)'(model_count());
      exp_q.push_back(e);
      // The rising edge of this cycle; while reset is held it changes nothing.
      if (!do_rst) begin
         if (wae && waa != 0) m_mem[waa] = wad;
         if (wbe && wba != 0) begin
            m_mem[wba]  = wbd;
            m_pend[wba] = 0;
         end
         if (rse && rsa != 0) m_pend[rsa] = 1;
      end
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      step(a0, a1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NUM_RD; i++) begin
               n_tests++;
               if (bus.rd_data[i*DATA_W +: DATA_W] !== e.data[i*DATA_W +: DATA_W]) begin
                  n_fail++;
                  $display("FAIL rd_data port%0d addr %0d at %0t: got %h want %h", i,
                           bus.rd_addr[i*ADDR_W +: ADDR_W], $time,
                           bus.rd_data[i*DATA_W +: DATA_W], e.data[i*DATA_W +: DATA_W]);
               end
               n_tests++;
               if (bus.rd_busy[i] !== e.busy[i]) begin
                  n_fail++;
                  $display("FAIL rd_busy port%0d addr %0d at %0t: got %b want %b", i,
                           bus.rd_addr[i*ADDR_W +: ADDR_W], $time, bus.rd_busy[i], e.busy[i]);
               end
            end
            n_tests++;
            if (bus.pend_cnt !== e.cnt) begin
               n_fail++;
               $display("FAIL pend_cnt at %0t: got %0d want %0d", $time, bus.pend_cnt, e.cnt);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int drain;
      // Reset state, then writes to r0 on both ports.
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 31, 1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 1, 0, 0);
      rd(0, 0);
      for (int a = 0; a < DEPTH; a++) rd(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
      // Port A write with a same-cycle read, then the next-cycle read.
      step(5, 5, 1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0);
      rd(5, 5);
      // A/B collision: port B wins.
      step(7, 0, 1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 0);
      rd(7, 7);
      // Reserve and load return.
      step(9, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      rd(9, 1);
      step(1, 9, 0, 0, 0, 1, 9, 32'hAA, 0, 0, 0);
      rd(9, 9);
      // Load return and new reserve on the same register.
      step(3, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
      step(3, 4, 0, 0, 0, 1, 3, 32'h3333, 1, 3, 0);
      rd(3, 3);
      step(4, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
      step(6, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
      step(8, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
      rd(8, 4);
      step(4, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);   // reserve an already-pending register
      rd(4, 6);
      // Populate and reserve, then an asynchronous reset in the middle of a cycle with writes present.
      step(1, 2, 1, 1, 32'h0101, 1, 2, 32'h0202, 0, 0, 0);
      step(1, 2, 1, 3, 32'h0303, 0, 0, 0, 1, 2, 0);
      rd(2, 3);
      step(1, 2, 1, 1, 32'hFFFF, 1, 3, 32'hEEEE, 1, 5, 1);
      rd(1, 2);
      rd(3, 5);
      // Randomized traffic; a narrow address window forces collisions.
      for (int n = 0; n < 600; n++) begin
         int hi;
         hi = ($urandom_range(0, 1) == 1) ? 3 : DEPTH - 1;
         step(ADDR_W'($urandom_range(0, hi)), ADDR_W'($urandom_range(0, hi)),
              1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, hi)), $urandom,
              1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, hi)), $urandom,
              1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, hi)),
              1'($urandom_range(0, 99) == 0));
      end
      rd(0, 0);
      drain = 0;
      while (exp_q.size() > 0 && drain < 20) begin
         @(negedge clk);
         drain++;
      end
      #5;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d entries left want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath; the successor to the single-write, two-read file. It adds configurable width, depth and read-port count, a second write port for late load returns, and a per-register pending scoreboard that flags operands still awaiting an outstanding load. Register 0 reads as zero and is never written or marked pending. Optional same-cycle write-to-read bypass.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries, entry 0 hardwired zero
- NUM_RD, 2, number of read ports (1..4)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i addresses a pending register
- wa_en  in  1  write port A enable (ALU writeback)
- wa_addr  in  ADDR_W  port A address
- wa_data  in  DATA_W  port A data
- wb_en  in  1  write port B enable (load return); clears pending
- wb_addr  in  ADDR_W  port B address
- wb_data  in  DATA_W  port B data
- rsv_en  in  1  reserve: mark rsv_addr pending (load issued)
- rsv_addr  in  ADDR_W  register to reserve
- pend_cnt  out  ADDR_W+1  number of pending registers

## Operation
- Storage: entries 1..2**ADDR_W-1 of DATA_W bits; pending bit per entry 1..N-1.
- Reads combinational: rd_data[i] = 0 when rd_addr[i]==0, else stored value (modified by bypass, see Configuration).
- rd_busy[i] = pending[rd_addr[i]]; always 0 for address 0.
- Writes to address 0 on either port ignored; rsv to address 0 ignored.
- Port A and port B same nonzero address same cycle: port B data wins.
- Port B write to addr X clears pending[X] at the edge. Port A write does not touch pending.
- rsv_en to X sets pending[X] at the edge; simultaneous port B write to X and rsv X: data written, pending ends set (new load supersedes).
- rsv to an already-pending register: stays set, no error.
- pend_cnt = population count of pending bits, registered (updated at same edge as pending).

## Timing
- Reset (asynchronous, immediate): all entries 0, all pending 0, pend_cnt 0; hence rd_data 0 and rd_busy 0 for every port.
- Write latency: data visible on read ports the cycle after the write edge (without bypass).
- Pending set/clear visible on rd_busy the cycle after the edge.
- pend_cnt reflects the pending state after each edge; range 0..2**ADDR_W-1.
- Reset asserted mid-operation overrides any same-cycle write or reserve; deasserting reset, first edge performs normal writes.
- No handshake; all inputs sampled every rising edge.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: a read of nonzero X in the same cycle as a write to X returns the write data combinationally (port B priority over port A); rd_busy[i] forced 0 when wb_en targets X that cycle and rsv_en does not also target X.
- Not defined: reads return the stored value only; new data and busy clear appear one cycle after the edge. Storage, pending and pend_cnt behaviour identical in both builds.

## Test plan
- Reset then read all addresses on every port -> rd_data 0, rd_busy 0, pend_cnt 0; write 0xDEADBEEF to r0 via A and B -> r0 still reads 0.
- Port A writes 0x12345678 to r5, next cycle read r5 on ports 0 and 1 -> both 0x12345678; same-cycle read returns old value without macro, 0x12345678 with REGFILE_BYPASS_EN.
- Same cycle A writes 0x1111 and B writes 0x2222 to r7 -> r7 reads 0x2222.
- rsv r9 -> next cycle rd_busy=1 for port reading r9, pend_cnt 1; B writes 0xAA to r9 -> next cycle busy 0, r9=0xAA, pend_cnt 0.
- Same cycle B writes r3 and rsv r3 -> r3 updated, pending stays 1, pend_cnt unchanged; rsv r4, r6, r8 -> pend_cnt 4.
- Populate r1..r3 and reserve r2, assert rst mid-cycle asynchronously -> registers, pending and pend_cnt 0 immediately before next edge.
